// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_pkg -- shared state and requester-ID types for mem_port_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    REFRESH = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    DL   = 2'd0,
    CPU  = 2'd1,
    VID  = 2'd2,
    RFSH = 2'd3
  } req_id_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_rr2 -- two-way cpu/video round-robin selector, cpu wins first tie
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_arb_rr2 (
  input  logic clock,
  input  logic reset_n,
  input  logic cpu_req,
  input  logic vid_req,
  input  logic advance,
  output logic grant_cpu,
  output logic grant_vid
);

  logic r_prefer_vid;

  always_comb begin
    grant_cpu = cpu_req && (!vid_req || !r_prefer_vid);
    grant_vid = vid_req && !grant_cpu;
  end

  // advance is raised only when the arbiter actually takes this grant
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prefer_vid <= 1'b0;
    end else if (advance) begin
      r_prefer_vid <= grant_cpu;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter -- single memory port shared by download, cpu and video,
//                     with periodic refresh and access timeout
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 780,
  parameter int TIMEOUT          = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              dl_req,
  input  logic              cpu_req,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              dl_we,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] dl_wdata,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              dl_ack,
  output logic              cpu_ack,
  output logic              vid_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_refresh,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  localparam int RCNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [RCNT_W-1:0] RCNT_LAST  = RCNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(TIMEOUT);

  arb_state_t        r_state;
  arb_state_t        w_next;
  req_id_t           r_gnt;
  req_id_t           w_sel;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [RCNT_W-1:0] r_rcnt;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_rfsh_pend;
  logic              r_timeout_err;
  logic              w_grant_cpu;
  logic              w_grant_vid;
  logic              w_rr_adv;
  logic              w_busy;
  logic              w_expired;
  logic              w_done;
  logic              w_wrap;

  mem_arb_rr2 u_rr (
    .clock     (clock),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .vid_req   (vid_req),
    .advance   (w_rr_adv),
    .grant_cpu (w_grant_cpu),
    .grant_vid (w_grant_vid)
  );

  assign w_busy    = (r_state == WAIT) || (r_state == REFRESH);
  assign w_expired = w_busy && (r_wcnt == WCNT_LIMIT);
  // an ack landing on the limit cycle is a normal completion
  assign w_done    = w_busy && (mem_ack || w_expired);
  assign w_wrap    = (r_rcnt == RCNT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_sel    = r_gnt;
    w_rr_adv = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_rfsh_pend) begin
          w_next = REFRESH;
          w_sel  = RFSH;
        end else if (dl_req) begin
          w_next = ISSUE;
          w_sel  = DL;
        end else if (w_grant_cpu) begin
          w_next   = ISSUE;
          w_sel    = CPU;
          w_rr_adv = 1'b1;
        end else if (w_grant_vid) begin
          w_next   = ISSUE;
          w_sel    = VID;
          w_rr_adv = 1'b1;
        end
      end
      ISSUE:         w_next = WAIT;
      WAIT, REFRESH: if (w_done) w_next = IDLE;
      default:       w_next = IDLE;
    endcase
  end

  always_comb begin
    dl_ack      = 1'b0;
    cpu_ack     = 1'b0;
    vid_ack     = 1'b0;
    rdata       = '0;
    mem_req     = (r_state == ISSUE);
    mem_we      = (r_state == ISSUE) && r_we;
    mem_refresh = (r_state == REFRESH) && (r_wcnt == '0);
    if ((r_state == WAIT) && w_done) begin
      rdata = mem_ack ? mem_rdata : 8'hFF;
      case (r_gnt)
        DL:      dl_ack  = 1'b1;
        CPU:     cpu_ack = 1'b1;
        VID:     vid_ack = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign timeout_err = r_timeout_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt   <= RFSH;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else if ((r_state == IDLE) && (w_next != IDLE)) begin
      r_gnt <= w_sel;
      case (w_sel)
        DL: begin
          r_addr  <= dl_addr;
          r_we    <= dl_we;
          r_wdata <= dl_wdata;
        end
        CPU: begin
          r_addr  <= cpu_addr;
          r_we    <= cpu_we;
          r_wdata <= cpu_wdata;
        end
        VID: begin
          r_addr  <= vid_addr;
          r_we    <= 1'b0;
          r_wdata <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rcnt        <= '0;
      r_rfsh_pend   <= 1'b0;
      r_wcnt        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_rcnt <= w_wrap ? '0 : r_rcnt + 1'b1;
      // a wrap while already pending simply leaves the single flag set
      if (w_wrap) begin
        r_rfsh_pend <= 1'b1;
      end else if ((r_state == REFRESH) && w_done) begin
        r_rfsh_pend <= 1'b0;
      end
      r_wcnt <= w_busy ? r_wcnt + 1'b1 : '0;
      if (w_expired && !mem_ack) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter -- directed vectors and corner sequences for the arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        dl_req, cpu_req, vid_req;
  logic [19:0] dl_addr, cpu_addr, vid_addr;
  logic        dl_we, cpu_we;
  logic [7:0]  dl_wdata, cpu_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  logic        a_dl_ack, a_cpu_ack, a_vid_ack, a_mem_req, a_mem_refresh, a_mem_we, a_timeout_err;
  logic [7:0]  a_rdata, a_mem_wdata;
  logic [19:0] a_mem_addr;
  logic        b_dl_ack, b_cpu_ack, b_vid_ack, b_mem_req, b_mem_refresh, b_mem_we, b_timeout_err;
  logic [7:0]  b_rdata, b_mem_wdata;
  logic [19:0] b_mem_addr;

  mem_port_arbiter #(.REFRESH_INTERVAL(5000), .TIMEOUT(8)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .dl_req(dl_req), .cpu_req(cpu_req), .vid_req(vid_req),
    .dl_addr(dl_addr), .cpu_addr(cpu_addr), .vid_addr(vid_addr),
    .dl_we(dl_we), .cpu_we(cpu_we), .dl_wdata(dl_wdata), .cpu_wdata(cpu_wdata),
    .dl_ack(a_dl_ack), .cpu_ack(a_cpu_ack), .vid_ack(a_vid_ack), .rdata(a_rdata),
    .mem_req(a_mem_req), .mem_refresh(a_mem_refresh), .mem_addr(a_mem_addr),
    .mem_we(a_mem_we), .mem_wdata(a_mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .timeout_err(a_timeout_err)
  );

  // short refresh period instance for the refresh ordering sequence
  mem_port_arbiter #(.REFRESH_INTERVAL(16), .TIMEOUT(8)) u_dut_rf (
    .clock(clock), .reset_n(reset_n),
    .dl_req(dl_req), .cpu_req(cpu_req), .vid_req(vid_req),
    .dl_addr(dl_addr), .cpu_addr(cpu_addr), .vid_addr(vid_addr),
    .dl_we(dl_we), .cpu_we(cpu_we), .dl_wdata(dl_wdata), .cpu_wdata(cpu_wdata),
    .dl_ack(b_dl_ack), .cpu_ack(b_cpu_ack), .vid_ack(b_vid_ack), .rdata(b_rdata),
    .mem_req(b_mem_req), .mem_refresh(b_mem_refresh), .mem_addr(b_mem_addr),
    .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .timeout_err(b_timeout_err)
  );

  typedef struct {
    logic [2:0]  req;      // {dl, cpu, vid}
    logic [19:0] addr;
    logic        we;
    logic [7:0]  wd;
    int          dly;      // cycles from mem_req to mem_ack
    logic [7:0]  rd;
    logic [2:0]  exp_ack;  // {dl, cpu, vid}
  } vec_t;

  typedef struct {
    int          lat;
    logic [19:0] addr;
    logic        we;
    logic [7:0]  wd;
    logic [2:0]  ack;
    logic [7:0]  rd;
    logic [2:0]  post_ack;
    logic        post_mreq;
  } txn_t;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[10];
  txn_t t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  function automatic logic [63:0] a_outs();
    return {21'b0, a_dl_ack, a_cpu_ack, a_vid_ack, a_mem_req, a_mem_refresh, a_mem_we,
            a_timeout_err, a_mem_addr, a_mem_wdata, a_rdata};
  endfunction

  task automatic apply_reset();
    dl_req = 0; cpu_req = 0; vid_req = 0; mem_ack = 0;
    @(negedge clock);
    reset_n = 0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic drive_vec(input vec_t v);
    {dl_req, cpu_req, vid_req} = v.req;
    dl_addr   = v.exp_ack[2] ? v.addr : 20'hD0D0D;
    dl_we     = v.exp_ack[2] ? v.we   : 1'b1;
    dl_wdata  = v.exp_ack[2] ? v.wd   : 8'hEE;
    cpu_addr  = v.exp_ack[1] ? v.addr : 20'hC0C0C;
    cpu_we    = v.exp_ack[1] ? v.we   : 1'b1;
    cpu_wdata = v.exp_ack[1] ? v.wd   : 8'hEE;
    vid_addr  = v.exp_ack[0] ? v.addr : 20'hB0B0B;
  endtask

  // one access on the main instance: find mem_req, ack after dly cycles, look one cycle past
  task automatic run_txn(input int dly, input logic [7:0] rd, input logic drop, output txn_t r);
    r = '{-1, 20'h0, 1'b0, 8'h0, 3'b0, 8'h0, 3'b0, 1'b0};
    for (int i = 1; i <= 20; i++) begin
      step();
      if (a_mem_req) begin
        r.lat = i; r.addr = a_mem_addr; r.we = a_mem_we; r.wd = a_mem_wdata;
        break;
      end
    end
    if (r.lat < 0) return;
    for (int i = 1; i < dly; i++) step();
    step();
    mem_ack = 1; mem_rdata = rd;
    #1;
    r.ack = {a_dl_ack, a_cpu_ack, a_vid_ack};
    r.rd  = a_rdata;
    if (drop) begin dl_req = 0; cpu_req = 0; vid_req = 0; end
    step();
    mem_ack = 0;
    #1;
    r.post_ack  = {a_dl_ack, a_cpu_ack, a_vid_ack};
    r.post_mreq = a_mem_req;
  endtask

  task automatic timeout_seq(input string tag, input logic give_ack, input logic [7:0] rd);
    logic quiet;
    apply_reset();
    vid_req = 1; vid_addr = 20'h0F0F0;
    step();
    check({tag, "_issue"}, 64'(a_mem_req), 64'(1));
    quiet = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      #1;
      if ({a_dl_ack, a_cpu_ack, a_vid_ack} != 3'b000) quiet = 1'b0;
    end
    check({tag, "_no_early_ack"}, 64'(quiet), 64'(1));
    step();
    mem_ack = give_ack; mem_rdata = rd;
    #1;
    check({tag, "_ack"}, 64'({a_dl_ack, a_cpu_ack, a_vid_ack}), 64'(3'b001));
    check({tag, "_rdata"}, 64'(a_rdata), 64'(give_ack ? rd : 8'hFF));
    vid_req = 0;
    step();
    mem_ack = 0;
    #1;
    check({tag, "_err"}, 64'(a_timeout_err), 64'(!give_ack));
    check({tag, "_ack_once"}, 64'({a_dl_ack, a_cpu_ack, a_vid_ack}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int ev[$];
    logic pend;

    reset_n = 0; mem_ack = 0; mem_rdata = 8'h00;
    dl_req = 0; cpu_req = 0; vid_req = 0;
    dl_addr = 0; cpu_addr = 0; vid_addr = 0;
    dl_we = 0; cpu_we = 0; dl_wdata = 0; cpu_wdata = 0;
    #13;
    check("reset_outputs", a_outs(), 64'(0));
    @(negedge clock);
    reset_n = 1;
    #1;
    check("post_reset_outputs", a_outs(), 64'(0));

    vecs[0] = '{3'b010, 20'h00400, 1'b0, 8'h00, 2, 8'h5A, 3'b010};
    vecs[1] = '{3'b011, 20'h0ABCD, 1'b0, 8'h00, 1, 8'h33, 3'b001};
    vecs[2] = '{3'b011, 20'h12345, 1'b1, 8'hC3, 1, 8'h77, 3'b010};
    vecs[3] = '{3'b111, 20'hFFFFF, 1'b1, 8'hA5, 3, 8'h01, 3'b100};
    vecs[4] = '{3'b011, 20'h00001, 1'b0, 8'h00, 1, 8'h80, 3'b001};
    vecs[5] = '{3'b001, 20'h55555, 1'b0, 8'h00, 1, 8'h11, 3'b001};
    vecs[6] = '{3'b011, 20'h00000, 1'b0, 8'h00, 1, 8'hFE, 3'b010};
    vecs[7] = '{3'b100, 20'h80000, 1'b1, 8'h00, 1, 8'h42, 3'b100};
    vecs[8] = '{3'b010, 20'h7FFFF, 1'b1, 8'hFF, 4, 8'h9C, 3'b010};
    vecs[9] = '{3'b011, 20'h3C3C3, 1'b0, 8'h00, 2, 8'h00, 3'b001};

    for (int k = 0; k < 10; k++) begin
      drive_vec(vecs[k]);
      run_txn(vecs[k].dly, vecs[k].rd, 1'b1, t);
      check($sformatf("v%0d_issue_lat", k), 64'(t.lat), 64'(1));
      check($sformatf("v%0d_mem_addr", k), 64'(t.addr), 64'(vecs[k].addr));
      check($sformatf("v%0d_mem_we", k), 64'(t.we), 64'(vecs[k].we));
      if (vecs[k].we) check($sformatf("v%0d_mem_wdata", k), 64'(t.wd), 64'(vecs[k].wd));
      check($sformatf("v%0d_ack", k), 64'(t.ack), 64'(vecs[k].exp_ack));
      check($sformatf("v%0d_rdata", k), 64'(t.rd), 64'(vecs[k].rd));
      check($sformatf("v%0d_ack_once", k), 64'(t.post_ack), 64'(0));
    end

    // cpu and video held high throughout: strict alternation, no re-grant in the ack cycle
    apply_reset();
    cpu_req = 1; vid_req = 1; cpu_we = 0; cpu_addr = 20'h11111; vid_addr = 20'h22222;
    for (int i = 0; i < 4; i++) begin
      run_txn(1, 8'h10 + 8'(i), 1'b0, t);
      check($sformatf("alt%0d_lat", i), 64'(t.lat), 64'(1));
      check($sformatf("alt%0d_ack", i), 64'(t.ack), 64'((i % 2 == 0) ? 3'b010 : 3'b001));
      check($sformatf("alt%0d_addr", i), 64'(t.addr), 64'((i % 2 == 0) ? 20'h11111 : 20'h22222));
      check($sformatf("alt%0d_gap", i), 64'(t.post_mreq), 64'(0));
    end
    cpu_req = 0; vid_req = 0;

    timeout_seq("tmo", 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step();
    check("tmo_err_sticky", 64'(a_timeout_err), 64'(1));
    timeout_seq("edge", 1'b1, 8'h3C);

    // ack while idle must not produce anything
    mem_ack = 1; mem_rdata = 8'h77;
    #1;
    check("idle_ack_ignored", 64'({a_dl_ack, a_cpu_ack, a_vid_ack, a_rdata}), 64'(0));
    step();
    mem_ack = 0;
    #1;
    check("idle_ack_no_issue", 64'({a_mem_req, a_mem_refresh}), 64'(0));

    // reset pulled in the middle of a WAIT
    apply_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00400;
    step();
    step();
    #1;
    reset_n = 0; mem_ack = 1; mem_rdata = 8'h5A;
    #1;
    check("rst_wait_outputs", a_outs(), 64'(0));
    @(negedge clock);
    check("rst_held_outputs", a_outs(), 64'(0));
    mem_ack = 0;
    reset_n = 1;
    #1;
    check("rst_release_outputs", a_outs(), 64'(0));
    run_txn(2, 8'h5A, 1'b1, t);
    check("rst_next_lat", 64'(t.lat), 64'(1));
    check("rst_next_ack", 64'(t.ack), 64'(3'b010));
    check("rst_next_rdata", 64'(t.rd), 64'(8'h5A));
    check("rst_next_addr", 64'(t.addr), 64'(20'h00400));

    // refresh flag appears after 16 edges; dl and cpu arrive in the same IDLE cycle
    apply_reset();
    dl_addr = 20'h0D0D0; dl_we = 0; cpu_addr = 20'h0C0C0; cpu_we = 0;
    for (int i = 0; i < 16; i++) step();
    dl_req = 1; cpu_req = 1;
    step();
    #1;
    check("rf_first_refresh", 64'(b_mem_refresh), 64'(1));
    if (b_mem_refresh) ev.push_back(3);
    pend = b_mem_refresh || b_mem_req;
    for (int i = 0; i < 30 && ev.size() < 3; i++) begin
      step();
      mem_ack = pend;
      pend = 1'b0;
      #1;
      if (b_dl_ack)  begin ev.push_back(0); dl_req = 0; end
      if (b_cpu_ack) begin ev.push_back(1); cpu_req = 0; end
      if (b_vid_ack) ev.push_back(2);
      if (b_mem_refresh) ev.push_back(3);
      if (b_mem_req || b_mem_refresh) pend = 1'b1;
    end
    mem_ack = 0;
    check("rf_event_count", 64'(ev.size()), 64'(3));
    check("rf_order0_refresh", 64'((ev.size() > 0) ? ev[0] : -1), 64'(3));
    check("rf_order1_dl", 64'((ev.size() > 1) ? ev[1] : -1), 64'(0));
    check("rf_order2_cpu", 64'((ev.size() > 2) ? ev[2] : -1), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
